// File: rtl/load_writeback_unit_pkg.sv
// Shared definitions for the load/writeback path:
// widths, RV32I load encodings, FSM states and legality helpers.
package load_writeback_unit_pkg;

   localparam int DATA_WIDTH   = 32;
   localparam int ADDR_WIDTH   = 32;
   localparam int NUM_REGISTER = 32;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WB   = 2'd2
   } state_t;

   function automatic logic f3_legal(input logic [2:0] f3);
      return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
             (f3 == F3_LBU) || (f3 == F3_LHU);
   endfunction

   function automatic logic misaligned(input logic [2:0] f3,
                                       input logic [1:0] off);
      logic m;
      m = 1'b0;
      if ((f3 == F3_LH) || (f3 == F3_LHU)) m = off[0];
      if (f3 == F3_LW) m = (off != 2'b00);
      return m;
   endfunction

endpackage

// File: rtl/load_writeback_unit_extend.sv
// Byte/half/word lane select with sign or zero extension.
// Pure combinational; reusable by a store/AMO return path.
module load_extend
   import load_writeback_unit_pkg::*;
#(
   parameter int DW = DATA_WIDTH
) (
   input  logic [2:0]    funct3,
   input  logic [1:0]    offset,
   input  logic [DW-1:0] word,
   output logic [DW-1:0] data
);

   logic [7:0]  b;
   logic [15:0] h;

   // Pick the addressed lane, then extend by load kind
   always_comb begin
      b    = word[{offset, 3'b000} +: 8];
      h    = word[{offset[1], 4'b0000} +: 16];
      data = '0;
      case (funct3)
         F3_LB:   data = {{(DW-8){b[7]}}, b};
         F3_LBU:  data = {{(DW-8){1'b0}}, b};
         F3_LH:   data = {{(DW-16){h[15]}}, h};
         F3_LHU:  data = {{(DW-16){1'b0}}, h};
         F3_LW:   data = word;
         default: data = '0;
      endcase
   end

endmodule

// File: rtl/load_writeback_unit.sv
// Multi-cycle load unit: checks, one word read via req/ack,
// then a single registered register-file write.
module load_writeback_unit
   import load_writeback_unit_pkg::*;
#(
   parameter int DATA_WIDTH     = load_writeback_unit_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH     = load_writeback_unit_pkg::ADDR_WIDTH,
   parameter int NUM_REGISTER   = load_writeback_unit_pkg::NUM_REGISTER,
   parameter int TIMEOUT_CYCLES = 255,
   localparam int RW = $clog2(NUM_REGISTER),
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_load_valid,
   output logic                  o_load_ready,
   input  logic [2:0]            i_funct3,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [RW-1:0]         i_rd_addr,
   output logic                  o_mem_req,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   input  logic                  i_mem_ack,
   input  logic [DATA_WIDTH-1:0] i_mem_rdata,
   output logic                  o_rf_we,
   output logic [RW-1:0]         o_rf_waddr,
   output logic [DATA_WIDTH-1:0] o_rf_wdata,
   output logic                  o_busy,
   output logic [RW-1:0]         o_pending_rd,
   output logic                  o_fault
);

   state_t                state;
   logic [2:0]            f3_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [RW-1:0]         rd_q;
   logic [CW-1:0]         cnt;
   logic [DATA_WIDTH-1:0] ext;

   load_extend #(.DW(DATA_WIDTH)) u_ext (
      .funct3 (f3_q),
      .offset (addr_q[1:0]),
      .word   (i_mem_rdata),
      .data   (ext)
   );

   assign o_load_ready = (state == IDLE);
   assign o_busy       = (state != IDLE);
   assign o_mem_req    = (state == REQ);
   assign o_mem_addr   = (state == REQ) ?
                         {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
   assign o_pending_rd = o_busy ? rd_q : '0;

   // FSM with registered fault pulse and writeback outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         f3_q       <= '0;
         addr_q     <= '0;
         rd_q       <= '0;
         cnt        <= '0;
         o_fault    <= 1'b0;
         o_rf_we    <= 1'b0;
         o_rf_waddr <= '0;
         o_rf_wdata <= '0;
      end else begin
         o_fault    <= 1'b0;
         o_rf_we    <= 1'b0;
         o_rf_waddr <= '0;
         o_rf_wdata <= '0;
         case (state)
            IDLE: begin
               if (i_load_valid) begin
                  if (!f3_legal(i_funct3) ||
                      misaligned(i_funct3, i_addr[1:0])) begin
                     o_fault <= 1'b1;
                  end else begin
                     f3_q   <= i_funct3;
                     addr_q <= i_addr;
                     rd_q   <= i_rd_addr;
                     cnt    <= '0;
                     state  <= REQ;
                  end
               end
            end
            REQ: begin
               if (i_mem_ack) begin
                  o_rf_we    <= (rd_q != '0);
                  o_rf_waddr <= rd_q;
                  o_rf_wdata <= ext;
                  cnt        <= '0;
                  state      <= WB;
               end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                  o_fault <= 1'b1;
                  cnt     <= '0;
                  state   <= IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            WB:      state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_writeback_unit.sv
// Directed bench for load_writeback_unit: vector table plus
// hand sequences for delayed ack, timeout and async reset.
module tb_load_writeback_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid;
   logic        ready;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [4:0]  rd_addr;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        ack;
   logic [31:0] rdata;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        busy;
   logic [4:0]  pending;
   logic        fault;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   load_writeback_unit #(.TIMEOUT_CYCLES(4)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_load_valid (valid),
      .o_load_ready (ready),
      .i_funct3     (funct3),
      .i_addr       (addr),
      .i_rd_addr    (rd_addr),
      .o_mem_req    (mem_req),
      .o_mem_addr   (mem_addr),
      .i_mem_ack    (ack),
      .i_mem_rdata  (rdata),
      .o_rf_we      (rf_we),
      .o_rf_waddr   (rf_waddr),
      .o_rf_wdata   (rf_wdata),
      .o_busy       (busy),
      .o_pending_rd (pending),
      .o_fault      (fault)
   );

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [4:0]  rd;
      logic [31:0] rdata;
      logic        exp_fault;
      logic [31:0] exp_wd;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic run_load(input logic [2:0] f3, input logic [31:0] a,
                           input logic [4:0] rd, input logic [31:0] rw,
                           input int dly, input logic exp_fault,
                           input logic [31:0] exp_wd);
      logic [31:0] wa;
      wa = {a[31:2], 2'b00};
      @(negedge clk);
      valid = 1'b1; funct3 = f3; addr = a; rd_addr = rd;
      @(negedge clk);
      valid = 1'b0;
      if (exp_fault) begin
         check("fault_pulse", {31'd0, fault}, 32'd1);
         check("fault_no_req", {31'd0, mem_req}, 32'd0);
         check("fault_idle", {31'd0, busy}, 32'd0);
         @(negedge clk);
         check("fault_once", {31'd0, fault}, 32'd0);
         check("fault_no_we", {31'd0, rf_we}, 32'd0);
         check("fault_no_req2", {31'd0, mem_req}, 32'd0);
      end else begin
         for (int i = 0; i <= dly; i++) begin
            check("req", {31'd0, mem_req}, 32'd1);
            check("mem_addr", mem_addr, wa);
            check("pending_rd", {27'd0, pending}, {27'd0, rd});
            check("not_ready", {31'd0, ready}, 32'd0);
            if (i == dly) begin
               ack = 1'b1; rdata = rw;
            end
            @(negedge clk);
         end
         ack = 1'b0;
         check("wb_req_low", {31'd0, mem_req}, 32'd0);
         check("wb_busy", {31'd0, busy}, 32'd1);
         check("wb_not_ready", {31'd0, ready}, 32'd0);
         check("wb_we", {31'd0, rf_we}, {31'd0, rd != 5'd0});
         check("wb_waddr", {27'd0, rf_waddr}, {27'd0, rd});
         if (rd != 5'd0) check("wb_wdata", rf_wdata, exp_wd);
         @(negedge clk);
         check("post_busy", {31'd0, busy}, 32'd0);
         check("post_ready", {31'd0, ready}, 32'd1);
         check("post_we", {31'd0, rf_we}, 32'd0);
         check("post_wdata", rf_wdata, 32'd0);
         check("post_fault", {31'd0, fault}, 32'd0);
      end
   endtask

   initial begin
      rst_n = 1'b0; valid = 1'b0; funct3 = '0; addr = '0;
      rd_addr = '0; ack = 1'b0; rdata = '0;

      vecs[0]  = '{3'b000, 32'h103, 5'd5,  32'h80FF_1234, 1'b0, 32'hFFFF_FF80};
      vecs[1]  = '{3'b100, 32'h101, 5'd7,  32'h80FF_1234, 1'b0, 32'h0000_0012};
      vecs[2]  = '{3'b001, 32'h102, 5'd1,  32'h80FF_1234, 1'b0, 32'hFFFF_80FF};
      vecs[3]  = '{3'b101, 32'h200, 5'd31, 32'hBEEF_8001, 1'b0, 32'h0000_8001};
      vecs[4]  = '{3'b010, 32'h300, 5'd0,  32'hDEAD_BEEF, 1'b0, 32'h0};
      vecs[5]  = '{3'b000, 32'h000, 5'd2,  32'h0000_007F, 1'b0, 32'h0000_007F};
      vecs[6]  = '{3'b010, 32'h301, 5'd3,  32'h0,         1'b1, 32'h0};
      vecs[7]  = '{3'b011, 32'h300, 5'd3,  32'h0,         1'b1, 32'h0};
      vecs[8]  = '{3'b001, 32'h101, 5'd3,  32'h0,         1'b1, 32'h0};
      vecs[9]  = '{3'b101, 32'h203, 5'd3,  32'h0,         1'b1, 32'h0};
      vecs[10] = '{3'b110, 32'h300, 5'd3,  32'h0,         1'b1, 32'h0};

      #12;
      check("rst_ready", {31'd0, ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_req", {31'd0, mem_req}, 32'd0);
      check("rst_we", {31'd0, rf_we}, 32'd0);
      check("rst_fault", {31'd0, fault}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < 11; v++)
         run_load(vecs[v].f3, vecs[v].a, vecs[v].rd, vecs[v].rdata,
                  0, vecs[v].exp_fault, vecs[v].exp_wd);

      // Delayed ack: request held for four cycles
      run_load(3'b101, 32'h202, 5'd6, 32'hBEEF_0001, 3, 1'b0,
               32'h0000_BEEF);

      // Timeout with no ack, then a late ack
      @(negedge clk);
      valid = 1'b1; funct3 = 3'b010; addr = 32'h400; rd_addr = 5'd4;
      @(negedge clk);
      valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("to_req", {31'd0, mem_req}, 32'd1);
         check("to_no_fault", {31'd0, fault}, 32'd0);
         @(negedge clk);
      end
      check("to_fault", {31'd0, fault}, 32'd1);
      check("to_idle", {31'd0, busy}, 32'd0);
      check("to_no_we", {31'd0, rf_we}, 32'd0);
      ack = 1'b1; rdata = 32'h1111_2222;
      @(negedge clk);
      ack = 1'b0;
      check("late_ack_we", {31'd0, rf_we}, 32'd0);
      check("late_ack_fault", {31'd0, fault}, 32'd0);
      check("late_ack_idle", {31'd0, busy}, 32'd0);

      // Async reset while in REQ with ack held through release
      @(negedge clk);
      valid = 1'b1; funct3 = 3'b010; addr = 32'h500; rd_addr = 5'd8;
      @(negedge clk);
      valid = 1'b0;
      check("pre_rst_req", {31'd0, mem_req}, 32'd1);
      ack = 1'b1; rdata = 32'hCAFE_F00D;
      #2 rst_n = 1'b0;
      #1;
      check("arst_req", {31'd0, mem_req}, 32'd0);
      check("arst_addr", mem_addr, 32'd0);
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_ready", {31'd0, ready}, 32'd1);
      check("arst_pending", {27'd0, pending}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("held_ack_we", {31'd0, rf_we}, 32'd0);
      check("held_ack_busy", {31'd0, busy}, 32'd0);
      ack = 1'b0;

      run_load(3'b010, 32'h400, 5'd9, 32'h1234_5678, 0, 1'b0,
               32'h1234_5678);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
